// File: rtl/snake_pkg.sv
// Constants and state type shared by the snake game blocks.
package snake_pkg;

  localparam int unsigned TICK_CNT_W   = 25;
  localparam int unsigned TICK_TIMEOUT = 30_000_000;

  typedef enum logic {
    IDLE,
    PEND
  } tick_state_e;

endpackage

// File: rtl/tick_receiver_if.sv
// Step handshake and tick status bundle between the tick receiver and the game engine.
interface tick_receiver_if
  import snake_pkg::*;
#(
  parameter int unsigned CNT_W = TICK_CNT_W
) ();

  logic             clk_slow_in;
  logic             step_ack;
  logic             clr;
  logic             step_req;
  logic             overrun;
  logic [7:0]       miss_cnt;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             timeout;

  modport master (
    output clk_slow_in,
    output step_ack,
    output clr,
    input  step_req,
    input  overrun,
    input  miss_cnt,
    input  period,
    input  period_valid,
    input  timeout
  );

  modport slave (
    input  clk_slow_in,
    input  step_ack,
    input  clr,
    output step_req,
    output overrun,
    output miss_cnt,
    output period,
    output period_valid,
    output timeout
  );

endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, followed by a rising-edge detector.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/tick_receiver.sv
// Turns slow-tick rising edges into a held step request, and tracks period, stalls and overruns.
module tick_receiver
  import snake_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = TICK_CNT_W,
  parameter int unsigned TIMEOUT     = TICK_TIMEOUT
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  tick_receiver_if.slave bus
);

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] ToLimit = CNT_W'(TIMEOUT - 1);

  logic             rise;
  logic             tick_level;
  logic             unused_tick_level;
  logic             overrun_evt;

  tick_state_e      state_q;
  logic             step_req_q;
  logic             overrun_q, overrun_d;
  logic [7:0]       miss_q, miss_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] period_q, period_d;
  logic             seen_q, seen_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (bus.clk_slow_in),
    .q_o    (tick_level),
    .rise_o (rise)
  );

  // Only the edge matters here; the synchronized level is not needed.
  assign unused_tick_level = tick_level;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      step_req_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_q    <= PEND;
            step_req_q <= 1'b1;
          end
        end
        PEND: begin
          // A rise coincident with the ack re-arms the request instead of dropping it.
          if (bus.step_ack && !rise) begin
            state_q    <= IDLE;
            step_req_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          step_req_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    overrun_evt = (state_q == PEND) && rise && !bus.step_ack;
    cnt_inc     = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);
    cnt_d       = rise ? '0 : cnt_inc;
    period_d    = rise ? cnt_inc : period_q;
    seen_d      = seen_q | rise;
    // The first interval runs from reset, so only the second rise yields a real period.
    valid_d     = valid_q | (rise & seen_q);
    timeout_d   = rise ? 1'b0 : (timeout_q | (cnt_q >= ToLimit));

    overrun_d = overrun_q;
    miss_d    = miss_q;
    if (bus.clr) begin
      overrun_d = overrun_evt;
      miss_d    = overrun_evt ? 8'd1 : 8'd0;
    end else if (overrun_evt) begin
      overrun_d = 1'b1;
      if (miss_q != 8'hff) begin
        miss_d = miss_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overrun_q <= 1'b0;
      miss_q    <= '0;
      cnt_q     <= '0;
      period_q  <= '0;
      seen_q    <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
      miss_q    <= miss_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      seen_q    <= seen_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.step_req     = step_req_q;
  assign bus.overrun      = overrun_q;
  assign bus.miss_cnt     = miss_q;
  assign bus.period       = period_q;
  assign bus.period_valid = valid_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_tick_receiver.sv
// Self-checking bench for tick_receiver: directed table, corner sequences and random traffic.
module tb_tick_receiver;

  localparam int S  = 2;
  localparam int W  = 8;
  localparam int T  = 20;
  localparam int PMAX = 255;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  tick_receiver_if #(.CNT_W(W)) bus_if ();

  tick_receiver #(
    .SYNC_STAGES (S),
    .CNT_W       (W),
    .TIMEOUT     (T)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: edge index e counts clock edges since reset release,
  // xs[j-1] is the input level sampled at edge j.
  bit xs[$];
  int e, last_r, rises, m_miss, m_period;
  bit m_pend, m_ovr, m_valid, m_to;

  function automatic bit xat(int j);
    if (j < 1 || j > xs.size()) return 1'b0;
    return xs[j-1];
  endfunction

  // True if a rise will be acted upon at the coming edge.
  function automatic bit next_rise();
    return xat(e + 1 - S) && !xat(e - S);
  endfunction

  task automatic model_reset();
    xs.delete();
    e = 0; last_r = 0; rises = 0; m_miss = 0; m_period = 0;
    m_pend = 0; m_ovr = 0; m_valid = 0; m_to = 0;
  endtask

  task automatic model_edge(bit x, bit ack, bit c);
    bit rise, evt;
    xs.push_back(x);
    e++;
    rise = xat(e - S) && !xat(e - S - 1);
    evt  = m_pend && rise && !ack;
    if (rise) m_pend = 1;
    else if (ack) m_pend = 0;
    if (c) begin
      m_ovr  = evt;
      m_miss = evt ? 1 : 0;
    end else if (evt) begin
      m_ovr  = 1;
      m_miss = (m_miss < 255) ? m_miss + 1 : 255;
    end
    if (rise) begin
      rises++;
      m_period = (e - last_r > PMAX) ? PMAX : e - last_r;
      if (rises >= 2) m_valid = 1;
      last_r = e;
      m_to   = 0;
    end else begin
      m_to = (e - last_r >= T);
    end
  endtask

  task automatic check(string name, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (edge %0d, t=%0t)", name, got, want, e, $time);
    end
  endtask

  task automatic check_model();
    check("step_req", int'(bus_if.step_req), int'(m_pend));
    check("overrun", int'(bus_if.overrun), int'(m_ovr));
    check("miss_cnt", int'(bus_if.miss_cnt), m_miss);
    check("period_valid", int'(bus_if.period_valid), int'(m_valid));
    check("timeout", int'(bus_if.timeout), int'(m_to));
    if (m_valid) check("period", int'(bus_if.period), m_period);
  endtask

  // Called at a falling edge: drive, let one rising edge pass, sample at the next falling edge.
  task automatic tick(bit x, bit ack, bit c, bit chk);
    bus_if.clk_slow_in = x;
    bus_if.step_ack    = ack;
    bus_if.clr         = c;
    @(posedge clk);
    model_edge(x, ack, c);
    @(negedge clk);
    if (chk) check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst step_req", int'(bus_if.step_req), 0);
    check("rst overrun", int'(bus_if.overrun), 0);
    check("rst miss_cnt", int'(bus_if.miss_cnt), 0);
    check("rst period", int'(bus_if.period), 0);
    check("rst period_valid", int'(bus_if.period_valid), 0);
    check("rst timeout", int'(bus_if.timeout), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic bit sq10(int k);
    return (k % 10) < 5;
  endfunction

  typedef struct {
    bit x, ack, c;
    bit req, ovr;
    int miss;
    bit valid;
    int period;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int  coinc;
    bit  x, ack, c;

    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 0, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 0, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{1, 0, 0, 1, 0, 0, 0, 7};
    tbl[7]  = '{1, 1, 0, 0, 0, 0, 0, 7};
    tbl[8]  = '{1, 1, 0, 0, 0, 0, 0, 7};
    tbl[9]  = '{1, 0, 0, 0, 0, 0, 0, 7};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 7};
    tbl[11] = '{1, 0, 0, 0, 0, 0, 0, 7};
    tbl[12] = '{1, 0, 0, 0, 0, 0, 0, 7};
    tbl[13] = '{1, 1, 0, 1, 0, 0, 1, 7};
    tbl[14] = '{0, 0, 0, 1, 0, 0, 1, 7};
    tbl[15] = '{1, 0, 0, 1, 0, 0, 1, 7};
    tbl[16] = '{1, 0, 0, 1, 0, 0, 1, 7};
    tbl[17] = '{1, 0, 0, 1, 1, 1, 1, 4};
    tbl[18] = '{1, 0, 1, 1, 0, 0, 1, 4};
    tbl[19] = '{0, 1, 0, 0, 0, 0, 1, 4};

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus_if.clk_slow_in = 1'b0;
    bus_if.step_ack    = 1'b0;
    bus_if.clr         = 1'b0;
    @(negedge clk);

    // Directed table: first step, ack/idle ack, coincident ack in IDLE, overrun, clr.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick(tbl[i].x, tbl[i].ack, tbl[i].c, 1'b0);
      check($sformatf("tbl[%0d] step_req", i), int'(bus_if.step_req), int'(tbl[i].req));
      check($sformatf("tbl[%0d] overrun", i), int'(bus_if.overrun), int'(tbl[i].ovr));
      check($sformatf("tbl[%0d] miss_cnt", i), int'(bus_if.miss_cnt), tbl[i].miss);
      check($sformatf("tbl[%0d] valid", i), int'(bus_if.period_valid), int'(tbl[i].valid));
      check($sformatf("tbl[%0d] period", i), int'(bus_if.period), tbl[i].period);
      check($sformatf("tbl[%0d] timeout", i), int'(bus_if.timeout), 0);
    end

    // Period 10, never acked: overrun on the second rise, saturation, then clr.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      tick(sq10(k), 1'b0, 1'b0, 1'b1);
      if (k == 12) begin
        check("ovr after 2nd rise", int'(bus_if.overrun), 1);
        check("miss after 2nd rise", int'(bus_if.miss_cnt), 1);
      end
    end
    check("miss saturated", int'(bus_if.miss_cnt), 255);
    tick(sq10(3000), 1'b0, 1'b1, 1'b1);
    check("clr overrun", int'(bus_if.overrun), 0);
    check("clr miss_cnt", int'(bus_if.miss_cnt), 0);

    // Period 10 with immediate ack, then an ack coincident with a rise while pending.
    do_reset();
    for (int k = 0; k < 40; k++) begin
      tick(sq10(k), bus_if.step_req, 1'b0, 1'b1);
      if (k == 12) begin
        check("period after 2nd rise", int'(bus_if.period), 10);
        check("valid after 2nd rise", int'(bus_if.period_valid), 1);
      end
    end
    coinc = 0;
    for (int k = 40; k < 60; k++) begin
      ack = m_pend && next_rise();
      tick(sq10(k), ack, 1'b0, 1'b1);
      if (ack) begin
        coinc++;
        check("coinc step_req", int'(bus_if.step_req), 1);
        check("coinc overrun", int'(bus_if.overrun), 0);
      end
    end
    check("coincident ack seen", int'(coinc > 0), 1);

    // Stalled tick: timeout exactly T cycles after the last rise, cleared by the next one.
    do_reset();
    for (int k = 0; k < 30; k++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      check($sformatf("timeout at edge %0d", e), int'(bus_if.timeout), int'(e >= 3 + T));
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    check("timeout held", int'(bus_if.timeout), 1);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    check("timeout cleared by rise", int'(bus_if.timeout), 0);

    // Random traffic against the model.
    do_reset();
    x = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(7) == 0) x = ~x;
      ack = ($urandom_range(2) == 0);
      c   = ($urandom_range(15) == 0);
      tick(x, ack, c, 1'b1);
    end

    // Reset while pending with miss_cnt=3 and the input held high.
    do_reset();
    for (int k = 0; k < 34; k++) tick(sq10(k), 1'b0, 1'b0, 1'b1);
    check("pre-reset miss_cnt", int'(bus_if.miss_cnt), 3);
    check("pre-reset step_req", int'(bus_if.step_req), 1);
    bus_if.clk_slow_in = 1'b1;
    #2;
    do_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    check("post-reset req edge2", int'(bus_if.step_req), 0);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    check("post-reset req edge3", int'(bus_if.step_req), 1);
    for (int k = 0; k < 10; k++) tick(1'b1, 1'b0, 1'b0, 1'b1);
    check("single rise, no overrun", int'(bus_if.overrun), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
